cff_branch_seq: RTL and testbench

- Control-side sequencer for conditional branches (brzr/brnz/brpl/brmi).
- Drives the micro-operations the conditional flip-flop responds to:
  - places Ra on BUS and pulses CONin;
  - samples the resulting CON flag;
  - computes PC + sign-extended C and loads PC only when CON is set.
- Sits between instruction fetch/decode and the datapath control lines.

---
 rtl/cff_branch_seq.sv | 161 ++++++++++++++++
 tb/tb_cff_branch_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cff_branch_seq.sv
// Conditional-branch sequencer: drives Ra->CON, PC+C->Z and a gated PC load for brzr/brnz/brpl/brmi.
// Optional early exit on a not-taken branch when CFF_BRANCH_SKIP_EN is defined.
module cff_branch_seq #(
    parameter logic [4:0]  BR_OPCODE = 5'b10010,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [31:0]      IR,
    input  logic             CON,
    output logic             busy,
    output logic             Gra,
    output logic             Rout,
    output logic             CONin,
    output logic             PCout,
    output logic             Yin,
    output logic             Cout,
    output logic [31:0]      c_sext,
    output logic             ADD,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCin,
    output logic             done,
    output logic             taken,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int unsigned C_W = 19;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_RA   = 3'd1,
        S_PC   = 3'd2,
        S_ADD  = 3'd3,
        S_LD   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [C_W-1:0]   c_q;
    logic             taken_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_br;
    logic             accept;
    logic             reject;
    logic             ir_unused;

    // Only the opcode and the C field of IR matter to this sequence.
    assign ir_unused = ^IR[26:19];

    assign is_br  = (IR[31:27] == BR_OPCODE);
    assign accept = (state == IDLE) && start && is_br;
    assign reject = (state == IDLE) && start && !is_br;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = S_RA;
            S_RA:    state_nxt = S_PC;
`ifdef CFF_BRANCH_SKIP_EN
            S_PC:    state_nxt = CON ? S_ADD : S_DONE;
`else
            S_PC:    state_nxt = S_ADD;
`endif
            S_ADD:   state_nxt = S_LD;
            S_LD:    state_nxt = S_DONE;
            S_DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latched C field, branch outcome, illegal flag and taken counter
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            c_q       <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            illegal_q <= reject;
            if (accept) begin
                c_q <= IR[C_W-1:0];
            end
            // CON is only trustworthy one cycle after the CONin pulse, i.e. in S_PC.
            if (state == S_PC) begin
                taken_q <= CON;
            end
            if ((state == S_DONE) && taken_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Output decode of state and taken_q
    always_comb begin
        busy    = 1'b0;
        Gra     = 1'b0;
        Rout    = 1'b0;
        CONin   = 1'b0;
        PCout   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        ADD     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        done    = 1'b0;
        taken   = 1'b0;
        case (state)
            S_RA: begin
                busy  = 1'b1;
                Gra   = 1'b1;
                Rout  = 1'b1;
                CONin = 1'b1;
            end
            S_PC: begin
                busy  = 1'b1;
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            S_ADD: begin
                busy = 1'b1;
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_LD: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                PCin    = taken_q;
            end
            S_DONE: begin
                busy  = 1'b1;
                done  = 1'b1;
                taken = taken_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign c_sext    = {{(32 - C_W){c_q[C_W-1]}}, c_q};
    assign illegal   = illegal_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_cff_branch_seq.sv
// Self-checking bench for cff_branch_seq: a per-cycle scoreboard of expected control vectors.
// The counter is narrowed to 4 bits so that wrap-around is reachable in a short run.
module tb_cff_branch_seq;

    localparam int unsigned CW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [31:0]   IR;
    logic          CON;
    logic          busy, Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin;
    logic          done, taken, illegal;
    logic [31:0]   c_sext;
    logic [CW-1:0] taken_cnt;

    cff_branch_seq #(.BR_OPCODE(5'b10010), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .IR(IR), .CON(CON),
        .busy(busy), .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout),
        .Yin(Yin), .Cout(Cout), .c_sext(c_sext), .ADD(ADD), .Zin(Zin),
        .Zlowout(Zlowout), .PCin(PCin), .done(done), .taken(taken),
        .illegal(illegal), .taken_cnt(taken_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic busy, gra, rout, conin, pcout, yin, cout, add, zin, zlowout, pcin, done, taken, illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t         c;
        logic [31:0]   cs;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_chk  = 0;
    int            n_pass = 0;
    logic [18:0]   m_c    = '0;
    logic [CW-1:0] m_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] sx(input logic [18:0] c);
        return {{13{c[18]}}, c};
    endfunction

    function automatic ctrl_t obs();
        return {busy, Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, done, taken, illegal};
    endfunction

    // Expected outputs for cycle 'st' (1..5) of a branch sequence.
    function automatic exp_t mk(input int st, input logic tk);
        exp_t e;
        e     = '0;
        e.cs  = sx(m_c);
        e.cnt = m_cnt;
        case (st)
            1: begin e.c.busy = 1; e.c.gra = 1; e.c.rout = 1; e.c.conin = 1; end
            2: begin e.c.busy = 1; e.c.pcout = 1; e.c.yin = 1; end
            3: begin e.c.busy = 1; e.c.cout = 1; e.c.add = 1; e.c.zin = 1; end
            4: begin e.c.busy = 1; e.c.zlowout = 1; e.c.pcin = tk; end
            5: begin e.c.busy = 1; e.c.done = 1; e.c.taken = tk; end
            default: e.c = '0;
        endcase
        return e;
    endfunction

    task automatic sample();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e     = '0;
            e.cs  = sx(m_c);
            e.cnt = m_cnt;
        end
        check("ctrl", 32'(obs()), 32'(e.c));
        check("c_sext", c_sext, e.cs);
        check("taken_cnt", 32'(taken_cnt), 32'(e.cnt));
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
        sample();
    endtask

    task automatic push_br(input logic [31:0] ir, input logic con);
        m_c = ir[18:0];
`ifdef CFF_BRANCH_SKIP_EN
        if (!con) begin
            sb.push_back(mk(1, 1'b0));
            sb.push_back(mk(2, 1'b0));
            sb.push_back(mk(5, 1'b0));
        end else
`endif
        for (int s = 1; s <= 5; s++) sb.push_back(mk(s, con));
        if (con) m_cnt = m_cnt + CW'(1);
    endtask

    // One branch; CON is wrong during S_RA and right only during S_PC.
    task automatic run_br(input logic [31:0] ir, input logic con, input logic poke_busy);
        IR    = ir;
        start = 1'b1;
        CON   = ~con;
        push_br(ir, con);
        cyc();
        start = 1'b0;
        cyc();
        CON = con;
        if (poke_busy) begin
            start = 1'b1;
            IR    = 32'h9003FFF0;
        end
        cyc();
        start = 1'b0;
        CON   = ~con;
        for (int i = 0; i < 8 && sb.size() > 0; i++) cyc();
        if (sb.size() != 0) begin
            check("seq_drain", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        IR    = '0;
        CON   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        sample();
        @(negedge Clk);
        Reset = 1'b0;
        cyc();

        // Reset asserted while in S_ADD
        IR    = 32'h90080010;
        start = 1'b1;
        CON   = 1'b0;
        push_br(IR, 1'b1);
        cyc();
        start = 1'b0;
        cyc();
        CON = 1'b1;
        cyc();
        #1;
        Reset = 1'b1;
        #1;
        sb.delete();
        m_c   = '0;
        m_cnt = '0;
        check("rst_mid_ctrl", 32'(obs()), 32'd0);
        check("rst_mid_csext", c_sext, 32'd0);
        check("rst_mid_cnt", 32'(taken_cnt), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        cyc();

        // Taken branch, positive offset
        run_br(32'h90080010, 1'b1, 1'b0);
        check("taken_csext", c_sext, 32'h00000010);
        check("taken_cnt1", 32'(taken_cnt), 32'd1);

        // Not-taken branch, negative offset
        run_br(32'h9087FFFF, 1'b0, 1'b0);
        check("ntaken_csext", c_sext, 32'hFFFFFFFF);

        // Illegal opcode: one-cycle pulse, C field unchanged
        IR    = 32'h08000000;
        start = 1'b1;
        begin
            exp_t e;
            e           = '0;
            e.c.illegal = 1'b1;
            e.cs        = sx(m_c);
            e.cnt       = m_cnt;
            sb.push_back(e);
        end
        cyc();
        start = 1'b0;
        cyc();
        cyc();

        // Start while busy is ignored
        run_br(32'h90000005, 1'b1, 1'b0);
        run_br(32'h97F40123, 1'b1, 1'b1);
        check("busy_csext", c_sext, 32'hFFFC0123);

        // A few random branches
        for (int i = 0; i < 4; i++) begin
            run_br({5'b10010, 27'($urandom)}, 1'($urandom), 1'($urandom));
        end

        // Counter wrap
        for (int i = 0; i < 20; i++) begin
            if (m_cnt == '1) break;
            run_br({5'b10010, 27'($urandom)}, 1'b1, 1'b0);
        end
        check("pre_wrap", 32'(taken_cnt), 32'(CW'('1)));
        run_br(32'h90000002, 1'b1, 1'b0);
        check("wrap", 32'(taken_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
